lightsaber_blade_sequencer: RTL and testbench
=============================================

LIGHTSABER_BLADE_SEQUENCER -- requirements
Module: lightsaber_blade_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter MODE_W, default 2: width of the blade-mode code.
REQ-003 Parameter MAX_MODE, default 3: highest legal mode code (0 Off, 1 Single, 2 Double, 3 Hilted).
REQ-004 Parameter RAMP_LEN, default 8: number of cycles for a full ignite or retract, legal range 1..255.
REQ-005 Derived constant LEN_W = clog2(RAMP_LEN+1): width of blade_len.
REQ-006 Port clk, input, 1 bit: rising-edge clock.
REQ-007 Port rst, input, 1 bit: synchronous active-high reset.
REQ-008 Port set_valid, input, 1 bit: a mode request is present.
REQ-009 Port set_mode, input, MODE_W bits: the requested mode.
REQ-010 Port set_ready, output, 1 bit: the block can accept a request this cycle.
REQ-011 Port mode_out, output, MODE_W bits: the active blade configuration.
REQ-012 Port blade_len, output, LEN_W bits: the current blade extension, 0..RAMP_LEN.
REQ-013 Port busy, output, 1 bit: an ignite or retract is in progress.
REQ-014 Port done, output, 1 bit: one-cycle pulse when a ramp sequence completes.
REQ-015 Port err, output, 1 bit: one-cycle pulse when an illegal mode is accepted.

Function
REQ-016 The FSM SHALL have the states OFF, IGNITE, ON and RETRACT.
REQ-017 A request SHALL be accepted on a rising edge where set_valid and set_ready are both 1.
REQ-018 set_ready SHALL be 1 in OFF and ON only, and 0 in IGNITE and RETRACT.
REQ-019 An accepted set_mode > MAX_MODE SHALL be ignored and SHALL cause err=1 for exactly the next cycle, with no state change.
REQ-020 OFF, accepted mode 0: stay in OFF, no done pulse.
REQ-021 OFF, accepted legal nonzero mode M: move to IGNITE on the accept edge; mode_out=M from that edge; blade_len stays 0.
REQ-022 In IGNITE, blade_len SHALL increment by 1 on each edge, reaching k on the k-th edge after accept.
REQ-023 On the edge where blade_len reaches RAMP_LEN, the FSM SHALL move to ON, and done=1 for that one cycle.
REQ-024 ON, accepted mode equal to mode_out: no-op, no done pulse.
REQ-025 ON, accepted mode 0: move to RETRACT and latch pending=0.
REQ-026 ON, accepted nonzero mode different from mode_out: move to RETRACT and latch pending=the new mode.
REQ-027 In RETRACT, blade_len SHALL decrement by 1 per edge, and mode_out SHALL hold the old mode.
REQ-028 RETRACT, blade_len reaching 0 with pending=0: on the same edge, move to OFF with mode_out=0, and done=1 for one cycle.
REQ-029 RETRACT, blade_len reaching 0 with pending nonzero: on the same edge, move to IGNITE with mode_out=pending, and no done pulse until the following ignite completes.
REQ-030 busy SHALL equal (state==IGNITE or state==RETRACT).
REQ-031 blade_len SHALL never wrap: no increment past RAMP_LEN and no decrement below 0.
REQ-032 With RAMP_LEN=1, the ignite and retract sequences SHALL each take exactly one edge.

Reset
REQ-033 When rst=1 at an edge, the block SHALL enter OFF, with mode_out=0, blade_len=0, pending=0 and busy=done=err=0; set_ready SHALL be 1 on the following cycle.
REQ-034 Reset SHALL take priority over any handshake on the same edge.
REQ-035 Reset mid-IGNITE or mid-RETRACT SHALL abort the ramp immediately, with no done pulse.

Structure
REQ-036 Package lightsaber_pkg SHALL hold the mode constants (MODE_OFF, MODE_SINGLE, MODE_DOUBLE, MODE_HILTED) and the FSM state encoding.
REQ-037 One sub-module, blade_ramp_counter, SHALL implement the saturating up/down counter (inputs inc, dec, clr; outputs count, at_max, at_zero).
REQ-038 The FSM, handshake, pending register and err/done generation SHALL reside in the top module.

Verification
REQ-039 Reset, then set mode 1 with RAMP_LEN=8 -> blade_len 0,1..8 on successive edges; done high one cycle when blade_len=8; mode_out=1 throughout.
REQ-040 In ON mode 1, request 3 -> retract 8 cycles with mode_out=1, then ignite 8 cycles with mode_out=3; exactly one done pulse, at the end.
REQ-041 In ON, request 0 -> blade_len 8..0, then OFF with mode_out=0; a request held during the ramp is accepted only once set_ready returns.
REQ-042 With MAX_MODE=2, request 3 from OFF -> err pulse one cycle; state, mode_out and blade_len unchanged.
REQ-043 Assert rst while blade_len=4 in IGNITE -> next cycle OFF, blade_len=0, mode_out=0, no done pulse.
REQ-044 In ON mode 2, request 2 -> no state change, no done pulse, set_ready stays 1.

Source files
------------

// File: rtl/lightsaber_pkg.sv
// Shared constants for the lightsaber blade sequencer: mode codes and FSM state encoding.
package lightsaber_pkg;

  localparam int MODE_OFF    = 0;
  localparam int MODE_SINGLE = 1;
  localparam int MODE_DOUBLE = 2;
  localparam int MODE_HILTED = 3;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_IGNITE  = 2'd1,
    ST_ON      = 2'd2,
    ST_RETRACT = 2'd3
  } state_t;

endpackage

// File: rtl/blade_ramp_counter.sv
// Saturating up/down counter that tracks blade extension between 0 and MAX_COUNT.
module blade_ramp_counter #(
  parameter int MAX_COUNT = 8,
  parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             at_max,
  output logic             at_zero
);

  assign at_max  = (count == CNT_W'(MAX_COUNT));
  assign at_zero = (count == '0);

  // Saturation keeps the count inside 0..MAX_COUNT even if inc/dec are held.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + CNT_W'(1);
    end else if (dec && !at_zero) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/lightsaber_blade_sequencer.sv
// Blade mode sequencer: accepts mode requests, ramps the blade out and back, and
// retracts before re-igniting whenever the blade configuration changes.
module lightsaber_blade_sequencer
  import lightsaber_pkg::*;
#(
  parameter  int MODE_W   = 2,
  parameter  int MAX_MODE = 3,
  parameter  int RAMP_LEN = 8,
  localparam int LEN_W    = $clog2(RAMP_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_valid,
  input  logic [MODE_W-1:0] set_mode,
  output logic              set_ready,
  output logic [MODE_W-1:0] mode_out,
  output logic [LEN_W-1:0]  blade_len,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [MODE_W:0]   MAX_EXT  = (MODE_W + 1)'(MAX_MODE);
  localparam logic [MODE_W-1:0] MODE_Z   = MODE_W'(MODE_OFF);

  state_t            state, state_n;
  logic [MODE_W-1:0] mode_n, pending, pending_n;
  logic              done_n, err_n;
  logic              inc, dec, at_max, at_zero;
  logic              accept, illegal, ign_last, ret_last;

  blade_ramp_counter #(
    .MAX_COUNT (RAMP_LEN),
    .CNT_W     (LEN_W)
  ) u_ramp (
    .clk     (clk),
    .clr     (rst),
    .inc     (inc),
    .dec     (dec),
    .count   (blade_len),
    .at_max  (at_max),
    .at_zero (at_zero)
  );

  assign set_ready = (state == ST_OFF) || (state == ST_ON);
  assign busy      = (state == ST_IGNITE) || (state == ST_RETRACT);
  assign accept    = set_valid && set_ready;
  assign illegal   = ({1'b0, set_mode} > MAX_EXT);
  // The FSM looks one step ahead so the state flips on the same edge the count lands.
  assign ign_last  = (blade_len == LEN_W'(RAMP_LEN - 1));
  assign ret_last  = (blade_len == LEN_W'(1));

  always_comb begin
    state_n   = state;
    mode_n    = mode_out;
    pending_n = pending;
    done_n    = 1'b0;
    err_n     = 1'b0;
    inc       = 1'b0;
    dec       = 1'b0;
    case (state)
      ST_OFF: begin
        if (accept) begin
          if (illegal) begin
            err_n = 1'b1;
          end else if (set_mode != MODE_Z) begin
            state_n = ST_IGNITE;
            mode_n  = set_mode;
          end
        end
      end
      ST_IGNITE: begin
        inc = !at_max;
        if (ign_last) begin
          state_n = ST_ON;
          done_n  = 1'b1;
        end
      end
      ST_ON: begin
        if (accept) begin
          if (illegal) begin
            err_n = 1'b1;
          end else if (set_mode != mode_out) begin
            state_n   = ST_RETRACT;
            pending_n = set_mode;
          end
        end
      end
      ST_RETRACT: begin
        dec = !at_zero;
        if (ret_last) begin
          if (pending == MODE_Z) begin
            state_n = ST_OFF;
            mode_n  = MODE_Z;
            done_n  = 1'b1;
          end else begin
            state_n   = ST_IGNITE;
            mode_n    = pending;
            pending_n = MODE_Z;
          end
        end
      end
      default: state_n = ST_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_OFF;
      mode_out <= '0;
      pending  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      mode_out <= mode_n;
      pending  <= pending_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_lightsaber_blade_sequencer.sv
// Bench for the blade sequencer: two configurations driven in parallel and compared
// every cycle against a ramp-direction model, plus directed literal checks.
module tb_lightsaber_blade_sequencer;

  typedef struct {
    int mode;
    int len;
    int dir;
    int pend;
    bit done;
    bit err;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_valid;
  logic [1:0] set_mode;

  logic       ready_a, busy_a, done_a, err_a;
  logic [1:0] mode_a;
  logic [3:0] len_a;
  logic       ready_b, busy_b, done_b, err_b;
  logic [1:0] mode_b;
  logic [0:0] len_b;

  int   errors = 0;
  int   checks = 0;
  bit   live   = 1'b0;
  mdl_t ma = '{0, 0, 0, 0, 1'b0, 1'b0};
  mdl_t mb = '{0, 0, 0, 0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  lightsaber_blade_sequencer #(.MODE_W(2), .MAX_MODE(3), .RAMP_LEN(8)) dut_a (
    .clk(clk), .rst(rst), .set_valid(set_valid), .set_mode(set_mode),
    .set_ready(ready_a), .mode_out(mode_a), .blade_len(len_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  lightsaber_blade_sequencer #(.MODE_W(2), .MAX_MODE(2), .RAMP_LEN(1)) dut_b (
    .clk(clk), .rst(rst), .set_valid(set_valid), .set_mode(set_mode),
    .set_ready(ready_b), .mode_out(mode_b), .blade_len(len_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  // Blade model: dir is +1 while extending, -1 while retracting, 0 when steady.
  function automatic mdl_t step(mdl_t m, bit r, bit v, int sm, int maxm, int ramp);
    mdl_t n = m;
    n.done = 1'b0;
    n.err  = 1'b0;
    if (r) begin
      n = '{0, 0, 0, 0, 1'b0, 1'b0};
    end else if (m.dir > 0) begin
      n.len = m.len + 1;
      if (n.len == ramp) begin
        n.dir  = 0;
        n.done = 1'b1;
      end
    end else if (m.dir < 0) begin
      n.len = m.len - 1;
      if (n.len == 0) begin
        n.mode = m.pend;
        n.dir  = (m.pend == 0) ? 0 : 1;
        n.done = (m.pend == 0);
        n.pend = 0;
      end
    end else if (v) begin
      if (sm > maxm) n.err = 1'b1;
      else if (sm != m.mode) begin
        if (m.mode == 0) begin
          n.mode = sm;
          n.dir  = 1;
        end else begin
          n.dir  = -1;
          n.pend = sm;
        end
      end
    end
    return n;
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    ma <= step(ma, rst, set_valid, int'(set_mode), 3, 8);
    mb <= step(mb, rst, set_valid, int'(set_mode), 2, 1);
  end

  always @(negedge clk) begin
    if (live) begin
      cmp("a_ready", int'(ready_a), int'(ma.dir == 0));
      cmp("a_busy",  int'(busy_a),  int'(ma.dir != 0));
      cmp("a_mode",  int'(mode_a),  ma.mode);
      cmp("a_len",   int'(len_a),   ma.len);
      cmp("a_done",  int'(done_a),  int'(ma.done));
      cmp("a_err",   int'(err_a),   int'(ma.err));
      cmp("b_ready", int'(ready_b), int'(mb.dir == 0));
      cmp("b_busy",  int'(busy_b),  int'(mb.dir != 0));
      cmp("b_mode",  int'(mode_b),  mb.mode);
      cmp("b_len",   int'(len_b),   mb.len);
      cmp("b_done",  int'(done_b),  int'(mb.done));
      cmp("b_err",   int'(err_b),   int'(mb.err));
    end
  end

  initial begin
    int dones;
    rst       = 1'b1;
    set_valid = 1'b0;
    set_mode  = 2'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    live = 1'b1;
    @(negedge clk);
    cmp("rst_len", int'(len_a), 0);
    cmp("rst_ready", int'(ready_a), 1);
    cmp("rst_mode", int'(mode_a), 0);

    // Ignite mode 1 from OFF.
    set_valid = 1'b1;
    set_mode  = 2'd1;
    @(posedge clk);
    #1 set_valid = 1'b0;
    @(negedge clk);
    cmp("acc_len", int'(len_a), 0);
    cmp("acc_mode", int'(mode_a), 1);
    cmp("acc_busy", int'(busy_a), 1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      cmp("ign_len", int'(len_a), k);
      cmp("ign_done", int'(done_a), int'(k == 8));
      cmp("ign_mode", int'(mode_a), 1);
    end

    // Switch mode 1 -> 3: full retract then full ignite, single done at the end.
    set_valid = 1'b1;
    set_mode  = 2'd3;
    @(posedge clk);
    #1 set_valid = 1'b0;
    dones = 0;
    for (int j = 0; j <= 16; j++) begin
      @(negedge clk);
      dones += int'(done_a);
      if (j == 4) begin
        cmp("swap_len4", int'(len_a), 4);
        cmp("swap_oldmode", int'(mode_a), 1);
      end
      if (j == 8) begin
        cmp("swap_len0", int'(len_a), 0);
        cmp("swap_newmode", int'(mode_a), 3);
      end
      if (j == 16) begin
        cmp("swap_len8", int'(len_a), 8);
        cmp("swap_done", int'(done_a), 1);
      end
    end
    cmp("swap_dones", dones, 1);

    // Same mode while ON is a no-op.
    set_valid = 1'b1;
    set_mode  = 2'd3;
    @(posedge clk);
    #1 set_valid = 1'b0;
    @(negedge clk);
    cmp("same_ready", int'(ready_a), 1);
    cmp("same_done", int'(done_a), 0);
    cmp("same_len", int'(len_a), 8);

    // Hold a mode-0 request through the retract.
    set_valid = 1'b1;
    set_mode  = 2'd0;
    repeat (12) @(negedge clk);
    cmp("off_mode", int'(mode_a), 0);
    cmp("off_len", int'(len_a), 0);
    cmp("off_ready", int'(ready_a), 1);
    set_valid = 1'b0;
    @(negedge clk);

    // Illegal mode on the MAX_MODE=2 instance.
    set_valid = 1'b1;
    set_mode  = 2'd3;
    @(posedge clk);
    #1 set_valid = 1'b0;
    @(negedge clk);
    cmp("ill_err", int'(err_b), 1);
    cmp("ill_mode", int'(mode_b), 0);
    cmp("ill_len", int'(len_b), 0);
    cmp("ill_ready", int'(ready_b), 1);
    @(negedge clk);
    cmp("ill_err_once", int'(err_b), 0);

    // Reset mid-ignite aborts the ramp.
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    set_valid = 1'b1;
    set_mode  = 2'd1;
    @(posedge clk);
    #1 set_valid = 1'b0;
    repeat (5) @(negedge clk);
    cmp("mid_len4", int'(len_a), 4);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    cmp("abort_len", int'(len_a), 0);
    cmp("abort_mode", int'(mode_a), 0);
    cmp("abort_busy", int'(busy_a), 0);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      dones += int'(done_a);
    end
    cmp("abort_nodone", dones, 0);

    // Randomized traffic.
    repeat (3000) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 99) == 0);
      set_valid = ($urandom_range(0, 2) == 0);
      set_mode  = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    rst       = 1'b0;
    set_valid = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
